// File: rtl/spi_i2s_shft_ctrl.sv
// SPI slave shift controller: command capture, word counting and FIFO strobes.
// Define SPI_SHFT_FIFO_WR_EN to build the FIFO_WR (host-to-device) receive path.
module spi_i2s_shft_ctrl #(
  parameter int WORD_BITS = 32
) (
  input  logic        i2s_clk_shft_tx,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        bit_en,
  input  logic        mosi,
  input  logic        tx_fifo_empty,
  input  logic        rx_fifo_full,
  output logic [3:0]  shft_state,
  output logic        rcv_cmd,
  output logic [7:0]  cmd_shft,
  output logic [5:0]  trans_cnt,
  output logic        tx_shft_first_load,
  output logic        tx_fifo_rd,
  output logic        rx_fifo_wr,
  output logic [31:0] rx_fifo_dat,
  output logic        cmd_err,
  output logic        xfer_err
);

  localparam logic [5:0] WORD_CNT = 6'(WORD_BITS);

  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    CMD       = 4'h6,
    STAREG_RD = 4'h7,
    FIFO_RD   = 4'h8,
    DREG_RD   = 4'h9,
    FIFO_WR   = 4'hA,
    IGNORE    = 4'hF
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rcv_q, rcv_d;
  logic        load_q, load_d;
  logic        rd_q, rd_d;
  logic        xerr_q, xerr_d;
  logic        cmd_known;
  state_e      cmd_target;

`ifdef SPI_SHFT_FIFO_WR_EN
  logic [WORD_BITS-1:0] rx_shft_q, rx_shft_d;
  logic [31:0]          rx_dat_q, rx_dat_d;
  logic                 wr_q, wr_d;
`endif

  always_comb begin
    cmd_known  = 1'b1;
    cmd_target = IGNORE;
    case (cmd_q)
      8'h80:   cmd_target = STAREG_RD;
      8'h90:   cmd_target = FIFO_RD;
      8'h98:   cmd_target = DREG_RD;
`ifdef SPI_SHFT_FIFO_WR_EN
      8'hA0:   cmd_target = FIFO_WR;
`endif
      default: cmd_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    rcv_d     = 1'b0;
    load_d    = 1'b0;
    rd_d      = 1'b0;
    xerr_d    = 1'b0;
`ifdef SPI_SHFT_FIFO_WR_EN
    rx_shft_d = rx_shft_q;
    rx_dat_d  = rx_dat_q;
    wr_d      = 1'b0;
`endif
    // Deselect wins over everything, including a bit_en in the same cycle.
    if (cs_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      cnt_d     = '0;
`ifdef SPI_SHFT_FIFO_WR_EN
      rx_shft_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
        CMD: begin
          if (rcv_q) begin
            state_d   = cmd_target;
            bit_cnt_d = '0;
          end else if (bit_en) begin
            cmd_d = {cmd_q[6:0], mosi};
            if (bit_cnt_q == 3'd7) begin
              rcv_d     = 1'b1;
              cnt_d     = WORD_CNT;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        STAREG_RD, DREG_RD: begin
          if (bit_en) begin
            if (cnt_q == 6'd1) begin
              cnt_d   = WORD_CNT;
              state_d = CMD;
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end
        end
        FIFO_RD: begin
          if (bit_en) begin
            load_d = (cnt_q == WORD_CNT);
            if (cnt_q == 6'd1) begin
              cnt_d  = WORD_CNT;
              rd_d   = ~tx_fifo_empty;
              xerr_d = tx_fifo_empty;
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end
        end
`ifdef SPI_SHFT_FIFO_WR_EN
        FIFO_WR: begin
          if (bit_en) begin
            rx_shft_d = {rx_shft_q[WORD_BITS-2:0], mosi};
            if (cnt_q == 6'd1) begin
              cnt_d = WORD_CNT;
              if (rx_fifo_full) begin
                xerr_d = 1'b1;
              end else begin
                wr_d                     = 1'b1;
                rx_dat_d                 = '0;
                rx_dat_d[WORD_BITS-1:0]  = rx_shft_d;
              end
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2s_clk_shft_tx or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      cnt_q     <= '0;
      rcv_q     <= 1'b0;
      load_q    <= 1'b0;
      rd_q      <= 1'b0;
      xerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      rcv_q     <= rcv_d;
      load_q    <= load_d;
      rd_q      <= rd_d;
      xerr_q    <= xerr_d;
    end
  end

`ifdef SPI_SHFT_FIFO_WR_EN
  always_ff @(posedge i2s_clk_shft_tx or posedge rst) begin
    if (rst) begin
      rx_shft_q <= '0;
      rx_dat_q  <= '0;
      wr_q      <= 1'b0;
    end else begin
      rx_shft_q <= rx_shft_d;
      rx_dat_q  <= rx_dat_d;
      wr_q      <= wr_d;
    end
  end

  assign rx_fifo_wr  = wr_q;
  assign rx_fifo_dat = rx_dat_q;
`else
  logic unused_rx_full;
  assign unused_rx_full = rx_fifo_full;
  assign rx_fifo_wr     = 1'b0;
  assign rx_fifo_dat    = '0;
`endif

  assign shft_state         = state_q;
  assign rcv_cmd            = rcv_q;
  assign cmd_shft           = cmd_q;
  assign trans_cnt          = cnt_q;
  assign tx_shft_first_load = load_q;
  assign tx_fifo_rd         = rd_q;
  assign xfer_err           = xerr_q;
  // Unknown opcode is flagged while the opcode is presented on cmd_shft.
  assign cmd_err            = rcv_q & ~cmd_known;

endmodule

// File: tb/tb_spi_i2s_shft_ctrl.sv
// Directed bench for spi_i2s_shft_ctrl: command table plus multi-cycle sequences.
module tb_spi_i2s_shft_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        bit_en = 1'b0;
  logic        mosi = 1'b0;
  logic        tx_fifo_empty = 1'b0;
  logic        rx_fifo_full = 1'b0;
  logic [3:0]  shft_state;
  logic        rcv_cmd;
  logic [7:0]  cmd_shft;
  logic [5:0]  trans_cnt;
  logic        tx_shft_first_load;
  logic        tx_fifo_rd;
  logic        rx_fifo_wr;
  logic [31:0] rx_fifo_dat;
  logic        cmd_err;
  logic        xfer_err;

  spi_i2s_shft_ctrl #(.WORD_BITS(32)) dut (
    .i2s_clk_shft_tx    (clk),
    .rst                (rst),
    .cs_n               (cs_n),
    .bit_en             (bit_en),
    .mosi               (mosi),
    .tx_fifo_empty      (tx_fifo_empty),
    .rx_fifo_full       (rx_fifo_full),
    .shft_state         (shft_state),
    .rcv_cmd            (rcv_cmd),
    .cmd_shft           (cmd_shft),
    .trans_cnt          (trans_cnt),
    .tx_shft_first_load (tx_shft_first_load),
    .tx_fifo_rd         (tx_fifo_rd),
    .rx_fifo_wr         (rx_fifo_wr),
    .rx_fifo_dat        (rx_fifo_dat),
    .cmd_err            (cmd_err),
    .xfer_err           (xfer_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_rcv, n_cmderr, n_load, n_rd, n_wr, n_xerr;
  int n_multi = 0;
  int n_idle_strb = 0;
  logic [7:0]  last_cmd;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] exp_state;
    logic       exp_err;
  } cmd_vec_t;

  cmd_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard / strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rcv_cmd) begin
      n_rcv++;
      last_cmd = cmd_shft;
    end
    if (cmd_err) n_cmderr++;
    if (tx_shft_first_load) n_load++;
    if (tx_fifo_rd) n_rd++;
    if (xfer_err) n_xerr++;
    if (rx_fifo_wr) begin
      n_wr++;
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("rx_fifo_dat_push", rx_fifo_dat, exp_w);
      end
    end
    if ((int'(tx_shft_first_load) + int'(tx_fifo_rd) + int'(rx_fifo_wr) + int'(xfer_err)) > 1)
      n_multi++;
    if (shft_state == 4'h0 &&
        (rcv_cmd | tx_shft_first_load | tx_fifo_rd | rx_fifo_wr | cmd_err | xfer_err))
      n_idle_strb++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_rcv = 0; n_cmderr = 0; n_load = 0; n_rd = 0; n_wr = 0; n_xerr = 0;
    last_cmd = 8'h00;
  endtask

  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    mosi   = b;
    tick();
    bit_en = 1'b0;
    mosi   = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  task automatic open_cmd(input logic [7:0] c);
    cs_n = 1'b1;
    tick();
    tick();
    clr_counts();
    cs_n = 1'b0;
    tick();
    check("state_after_cs_low", 32'(shft_state), 32'h6);
    send_bits(32'(c), 8);
  endtask

  task automatic close_xfer();
    cs_n = 1'b1;
    tick();
    check("state_after_cs_high", 32'(shft_state), 32'h0);
    check("trans_cnt_after_cs_high", 32'(trans_cnt), 32'h0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state"}, 32'(shft_state), 32'h0);
    check({name, "_cmd_shft"}, 32'(cmd_shft), 32'h0);
    check({name, "_trans_cnt"}, 32'(trans_cnt), 32'h0);
    check({name, "_rx_fifo_dat"}, rx_fifo_dat, 32'h0);
    check({name, "_strobes"},
          32'({rcv_cmd, tx_shft_first_load, tx_fifo_rd, rx_fifo_wr, cmd_err, xfer_err}), 32'h0);
  endtask

  initial begin
    vecs[0] = '{8'h80, 4'h7, 1'b0};
    vecs[1] = '{8'h90, 4'h8, 1'b0};
    vecs[2] = '{8'h98, 4'h9, 1'b0};
`ifdef SPI_SHFT_FIFO_WR_EN
    vecs[3] = '{8'hA0, 4'hA, 1'b0};
`else
    vecs[3] = '{8'hA0, 4'hF, 1'b1};
`endif
    vecs[4] = '{8'h55, 4'hF, 1'b1};
    vecs[5] = '{8'h00, 4'hF, 1'b1};
    vecs[6] = '{8'hFF, 4'hF, 1'b1};
    vecs[7] = '{8'h81, 4'hF, 1'b1};
    clr_counts();

    // reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    tick();
    check("idle_after_reset", 32'(shft_state), 32'h0);

    // command decode table
    foreach (vecs[k]) begin
      open_cmd(vecs[k].cmd);
      check("rcv_cmd_count", 32'(n_rcv), 32'd1);
      check("cmd_shft_at_rcv", 32'(last_cmd), 32'(vecs[k].cmd));
      check("cmd_err_count", 32'(n_cmderr), 32'(vecs[k].exp_err));
      check("decoded_state", 32'(shft_state), 32'(vecs[k].exp_state));
      check("trans_cnt_loaded", 32'(trans_cnt), 32'd32);
      close_xfer();
    end

    // status read: one word, then back to CMD for a following command
    open_cmd(8'h80);
    send_bits(32'h0, 31);
    check("stareg_state_mid", 32'(shft_state), 32'h7);
    check("stareg_cnt_last", 32'(trans_cnt), 32'd1);
    send_bit(1'b0);
    check("stareg_back_to_cmd", 32'(shft_state), 32'h6);
    check("stareg_cnt_wrapped", 32'(trans_cnt), 32'd32);
    send_bits(32'h98, 8);
    check("second_cmd_state", 32'(shft_state), 32'h9);
    check("second_cmd_rcv", 32'(n_rcv), 32'd2);
    check("second_cmd_value", 32'(last_cmd), 32'h98);
    close_xfer();

    // FIFO read streaming, then underflow on an empty FIFO
    tx_fifo_empty = 1'b0;
    open_cmd(8'h90);
    send_bits(32'h0, 32);
    send_bits(32'hFFFFFFFF, 32);
    check("fifo_rd_state", 32'(shft_state), 32'h8);
    check("fifo_rd_pops", 32'(n_rd), 32'd2);
    check("fifo_rd_loads", 32'(n_load), 32'd2);
    check("fifo_rd_cnt", 32'(trans_cnt), 32'd32);
    tx_fifo_empty = 1'b1;
    send_bits(32'h0, 32);
    check("fifo_rd_empty_pops", 32'(n_rd), 32'd2);
    check("fifo_rd_empty_xerr", 32'(n_xerr), 32'd1);
    check("fifo_rd_empty_loads", 32'(n_load), 32'd3);
    close_xfer();
    tx_fifo_empty = 1'b0;

    // cs_n high coincident with the word-boundary bit_en
    open_cmd(8'h90);
    send_bits(32'h0, 31);
    check("coinc_cnt_before", 32'(trans_cnt), 32'd1);
    cs_n   = 1'b1;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    check("coinc_state", 32'(shft_state), 32'h0);
    tick();
    tick();
    check("coinc_no_pop", 32'(n_rd), 32'd0);
    check("coinc_no_xerr", 32'(n_xerr), 32'd0);

`ifdef SPI_SHFT_FIFO_WR_EN
    // FIFO write: one pushed word, then one dropped on a full FIFO
    rx_fifo_full = 1'b0;
    open_cmd(8'hA0);
    exp_q.push_back(32'hDEADBEEF);
    send_bits(32'hDEADBEEF, 32);
    check("fifo_wr_pushes", 32'(n_wr), 32'd1);
    check("fifo_wr_sb_empty", 32'(exp_q.size()), 32'd0);
    check("fifo_wr_dat_held", rx_fifo_dat, 32'hDEADBEEF);
    check("fifo_wr_state", 32'(shft_state), 32'hA);
    rx_fifo_full = 1'b1;
    send_bits(32'h12345678, 32);
    check("fifo_wr_full_pushes", 32'(n_wr), 32'd1);
    check("fifo_wr_full_xerr", 32'(n_xerr), 32'd1);
    check("fifo_wr_full_dat", rx_fifo_dat, 32'hDEADBEEF);
    close_xfer();
    rx_fifo_full = 1'b0;
`else
    // FIFO write path absent: 8'hA0 is unknown and nothing is pushed
    open_cmd(8'hA0);
    check("a0_cmd_err", 32'(n_cmderr), 32'd1);
    send_bits(32'hDEADBEEF, 32);
    check("a0_state", 32'(shft_state), 32'hF);
    check("a0_no_push", 32'(n_wr), 32'd0);
    check("a0_dat_zero", rx_fifo_dat, 32'h0);
    close_xfer();
`endif

    // unknown command is ignored until deselect
    open_cmd(8'h55);
    send_bits(32'hFFFFFFFF, 32);
    send_bits(32'hFF, 8);
    check("ignore_state", 32'(shft_state), 32'hF);
    check("ignore_cmd_err", 32'(n_cmderr), 32'd1);
    check("ignore_strobes", 32'(n_load + n_rd + n_wr + n_xerr), 32'd0);
    close_xfer();

    // abort a write after 17 data bits
    open_cmd(8'hA0);
    send_bits(32'h1ABCD, 17);
`ifdef SPI_SHFT_FIFO_WR_EN
    check("abort_cnt_mid", 32'(trans_cnt), 32'd15);
`endif
    close_xfer();
    tick();
    tick();
    check("abort_no_push", 32'(n_wr), 32'd0);

    // asynchronous reset in the middle of a FIFO read
    open_cmd(8'h90);
    send_bits(32'h3FF, 10);
    check("rst_mid_state", 32'(shft_state), 32'h8);
    check("rst_mid_cnt", 32'(trans_cnt), 32'd22);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    cs_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rst_release_idle", 32'(shft_state), 32'h0);
    check("rst_no_pop", 32'(n_rd), 32'd0);
    cs_n = 1'b0;
    tick();
    check("rst_fresh_cs", 32'(shft_state), 32'h6);
    send_bits(32'h80, 8);
    check("rst_fresh_cmd", 32'(shft_state), 32'h7);
    close_xfer();

    check("one_strobe_per_bit", 32'(n_multi), 32'd0);
    check("no_strobe_in_idle", 32'(n_idle_strb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
